// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multi-cycle ALU with iterative multiply/divide engine
//
// Purpose: single-cycle arithmetic/logic/compare ops plus an iterative
// shift-add multiplier and restoring divider (one bit per clock), with a
// start/busy/done handshake. All results and flags are registered.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             launch an operation (sampled only while idle)
//   controle[3:0]     opcode (0 adc .. 13 div, 14/15 produce zeros)
//   sinal             1 = two's complement interpretation
//   DA, DB            operands, captured at the start edge
//   ULAresult, ULAhi  result / low product / quotient, high product / remainder
//   zero, negativo    decoded from the registered ULAresult
//   overflow, divzero registered flags
//   busy, done        in-flight indicator, one-cycle completion pulse
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       controle,
  input  logic             sinal,
  input  logic [WIDTH-1:0] DA,
  input  logic [WIDTH-1:0] DB,
  output logic [WIDTH-1:0] ULAresult,
  output logic [WIDTH-1:0] ULAhi,
  output logic             zero,
  output logic             negativo,
  output logic             overflow,
  output logic             divzero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADC = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_NOT = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_BEQ = 4'd7,
                         OP_BNEQ = 4'd8, OP_BLZ = 4'd9, OP_SLT = 4'd10, OP_SGT = 4'd11,
                         OP_MULT = 4'd12, OP_DIV = 4'd13;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;        // partial product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;        // multiplier bits / dividend-quotient shift register
  logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d; // product / quotient must be negated
  logic             neg_hi_q, neg_hi_d; // remainder must be negated
  logic             sgn_q, sgn_d;
  logic             div_ovf_q, div_ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] ulahi_q, ulahi_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_ovf, sc_dz;
  logic [WIDTH:0]   add_w, sub_w;
  logic             lt_bit, gt_bit;

  always_comb begin
    add_w  = {1'b0, DA} + {1'b0, DB};
    sub_w  = {1'b0, DA} - {1'b0, DB};
    lt_bit = sinal ? ($signed(DA) < $signed(DB)) : (DA < DB);
    gt_bit = sinal ? ($signed(DA) > $signed(DB)) : (DA > DB);
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dz  = 1'b0;
    case (controle)
      OP_ADC: begin
        sc_res = add_w[WIDTH-1:0];
        sc_ovf = sinal ? ((DA[WIDTH-1] == DB[WIDTH-1]) && (add_w[WIDTH-1] != DA[WIDTH-1]))
                       : add_w[WIDTH];
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        // bit WIDTH of the widened difference is the unsigned borrow
        sc_ovf = sinal ? ((DA[WIDTH-1] != DB[WIDTH-1]) && (sub_w[WIDTH-1] != DA[WIDTH-1]))
                       : sub_w[WIDTH];
      end
      OP_AND:  sc_res = DA & DB;
      OP_OR:   sc_res = DA | DB;
      OP_NOT:  sc_res = ~DA;
      OP_SLL:  sc_res = DA << DB[SHW-1:0];
      OP_SRL:  sc_res = DA >> DB[SHW-1:0];
      OP_BEQ:  sc_res = {{(WIDTH-1){1'b0}}, (DA != DB)};
      OP_BNEQ: sc_res = {{(WIDTH-1){1'b0}}, (DA != DB)};
      OP_BLZ:  sc_res = DA;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, lt_bit};
      OP_SGT:  sc_res = {{(WIDTH-1){1'b0}}, gt_bit};
      OP_DIV: begin
        // only reached with DB == 0; valid divides go through the engine
        sc_res = '1;
        sc_hi  = DA;
        sc_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  // Iterative engine helpers
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_sub;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    mag_a     = (sinal && DA[WIDTH-1]) ? (~DA + 1'b1) : DA;
    mag_b     = (sinal && DB[WIDTH-1]) ? (~DB + 1'b1) : DB;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_sub   = div_shift - {1'b0, opnd_q};
    prod      = neg_lo_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    quo       = neg_lo_q ? (~lo_q + 1'b1) : lo_q;
    rem       = neg_hi_q ? (~hi_q + 1'b1) : hi_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    sgn_d     = sgn_q;
    div_ovf_d = div_ovf_q;
    result_d  = result_q;
    ulahi_d   = ulahi_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (controle == OP_MULT || (controle == OP_DIV && DB != '0)) begin
            is_div_d  = (controle == OP_DIV);
            hi_d      = '0;
            lo_d      = (controle == OP_DIV) ? mag_a : mag_b;
            opnd_d    = (controle == OP_DIV) ? mag_b : mag_a;
            neg_lo_d  = sinal && (DA[WIDTH-1] ^ DB[WIDTH-1]);
            neg_hi_d  = sinal && DA[WIDTH-1];
            sgn_d     = sinal;
            div_ovf_d = (controle == OP_DIV) && sinal && (DA == MIN_VAL) && (DB == '1);
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = CALC;
          end else begin
            result_d = sc_res;
            ulahi_d  = sc_hi;
            ovf_d    = sc_ovf;
            dz_d     = sc_dz;
            done_d   = 1'b1;
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          // restoring step: shift in next dividend bit, subtract if it fits
          if (!div_sub[WIDTH]) begin
            hi_d = div_sub[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // shift-add step: conditional add into the high half, then shift right
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FINISH;
      end
      FINISH: begin
        if (is_div_q) begin
          result_d = quo;
          ulahi_d  = rem;
          ovf_d    = div_ovf_q;
        end else begin
          result_d = prod[WIDTH-1:0];
          ulahi_d  = prod[2*WIDTH-1:WIDTH];
          ovf_d    = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                           : (prod[2*WIDTH-1:WIDTH] != '0);
        end
        dz_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      sgn_q     <= 1'b0;
      div_ovf_q <= 1'b0;
      result_q  <= '0;
      ulahi_q   <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      sgn_q     <= sgn_d;
      div_ovf_q <= div_ovf_d;
      result_q  <= result_d;
      ulahi_q   <= ulahi_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ULAresult = result_q;
  assign ULAhi     = ulahi_q;
  assign zero      = (result_q == '0);
  assign negativo  = result_q[WIDTH-1];
  assign overflow  = ovf_q;
  assign divzero   = dz_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - scoreboard bench for ula_multiciclo
module tb_ula_multiciclo;

  localparam int W = 32;
  localparam longint MAXU = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         ovf;
    logic         dz;
    int           lat;
    int           dcyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   controle = 4'd0;
  logic         sinal = 1'b0;
  logic [W-1:0] DA = '0, DB = '0;
  logic [W-1:0] ULAresult, ULAhi;
  logic         zero, negativo, overflow, divzero, busy, done;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .controle(controle), .sinal(sinal),
    .DA(DA), .DB(DB), .ULAresult(ULAresult), .ULAhi(ULAhi), .zero(zero),
    .negativo(negativo), .overflow(overflow), .divzero(divzero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb_q[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;
  int ncmp = 0;
  logic [W-1:0] last_res = '0, last_hi = '0;
  logic         last_ovf = 1'b0, last_dz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    ncmp++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input int op, input bit s, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    longint xa, xb, full, p, q, r;
    logic [63:0] pv, qv, rv;
    xa = s ? longint'($signed(a)) : longint'(a);
    xb = s ? longint'($signed(b)) : longint'(b);
    e.res = '0; e.hi = '0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 0; e.dcyc = 0;
    case (op)
      0: begin
        full = xa + xb; pv = full; e.res = pv[31:0];
        e.ovf = s ? (full > MAXS || full < MINS) : (full > MAXU);
      end
      1: begin
        full = xa - xb; pv = full; e.res = pv[31:0];
        e.ovf = s ? (full > MAXS || full < MINS) : (full < 0);
      end
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = ~a;
      5: e.res = a << (b % 32);
      6: e.res = a >> (b % 32);
      7: e.res = (a == b) ? 32'd0 : 32'd1;
      8: e.res = (a != b) ? 32'd1 : 32'd0;
      9: e.res = a;
      10: e.res = (xa < xb) ? 32'd1 : 32'd0;
      11: e.res = (xa > xb) ? 32'd1 : 32'd0;
      12: begin
        p = xa * xb; pv = p;
        e.res = pv[31:0]; e.hi = pv[63:32];
        e.ovf = s ? (p != longint'($signed(pv[31:0]))) : (pv[63:32] != 0);
        e.lat = W + 1;
      end
      13: begin
        if (b == 0) begin
          e.res = '1; e.hi = a; e.dz = 1'b1;
        end else begin
          e.lat = W + 1;
          if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000; e.hi = '0; e.ovf = 1'b1;
          end else begin
            q = xa / xb; r = xa % xb; qv = q; rv = r;
            e.res = qv[31:0]; e.hi = rv[31:0];
          end
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse, checks holding otherwise.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_res = '0; last_hi = '0; last_ovf = 1'b0; last_dz = 1'b0;
    end else if (done) begin
      chk("busy_with_done", {63'd0, busy}, 64'd0);
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        vectors++;
        chk("ULAresult", {32'd0, ULAresult}, {32'd0, mon_e.res});
        chk("ULAhi", {32'd0, ULAhi}, {32'd0, mon_e.hi});
        chk("overflow", {63'd0, overflow}, {63'd0, mon_e.ovf});
        chk("divzero", {63'd0, divzero}, {63'd0, mon_e.dz});
        chk("zero", {63'd0, zero}, {63'd0, (mon_e.res == 0)});
        chk("negativo", {63'd0, negativo}, {63'd0, mon_e.res[W-1]});
        chk("done_cycle", 64'(cyc), 64'(mon_e.dcyc));
        last_res = mon_e.res; last_hi = mon_e.hi; last_ovf = mon_e.ovf; last_dz = mon_e.dz;
      end
    end else begin
      if (ULAresult !== last_res || ULAhi !== last_hi || overflow !== last_ovf ||
          divzero !== last_dz) begin
        miscompares++;
        $display("FAIL hold: got %h/%h/%b/%b expected %h/%h/%b/%b (cycle %0d)",
                 ULAresult, ULAhi, overflow, divzero, last_res, last_hi, last_ovf, last_dz, cyc);
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_ULAresult", {32'd0, ULAresult}, 64'd0);
    chk("rst_ULAhi", {32'd0, ULAhi}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    chk("rst_negativo", {63'd0, negativo}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_divzero", {63'd0, divzero}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
  endtask

  // Driver: called at a falling edge; returns at the falling edge after the start edge.
  task automatic issue(input int op, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      miscompares++;
      $display("FAIL busy_timeout: got busy=1 expected 0 within 200 cycles");
      return;
    end
    e = model(op, s, a, b);
    e.dcyc = cyc + 1 + e.lat;
    sb_q.push_back(e);
    controle = op[3:0]; sinal = s; DA = a; DB = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, {63'd0, (e.lat > 0)});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    check_reset_state();
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a multiply
    issue(12, 1'b1, 32'hFFFF_FFFD, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1 check_reset_state();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(0, 1'b0, 32'd3, 32'd4);

    // Directed boundary cases
    issue(0, 1'b1, 32'h7FFF_FFFF, 32'd1);
    issue(0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    issue(0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    issue(1, 1'b1, 32'h8000_0000, 32'd1);
    issue(1, 1'b0, 32'd1, 32'd2);
    issue(12, 1'b1, 32'hFFFF_FFFD, 32'd7);
    issue(12, 1'b0, 32'h0001_0000, 32'h0001_0000);
    issue(13, 1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(13, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(13, 1'b0, 32'd5, 32'd0);
    issue(14, 1'b0, 32'd9, 32'd9);
    issue(15, 1'b1, 32'h1234, 32'h5678);
    issue(7, 1'b0, 32'd5, 32'd5);
    issue(8, 1'b0, 32'd5, 32'd6);
    issue(10, 1'b1, 32'hFFFF_FFFF, 32'd1);
    issue(11, 1'b0, 32'hFFFF_FFFF, 32'd1);
    issue(5, 1'b0, 32'h0000_0001, 32'd31);

    // start pulsed while busy and operand changes during CALC must be ignored
    issue(12, 1'b0, 32'd1234567, 32'd89);
    start = 1'b1; controle = 4'd0; DA = 32'd1; DB = 32'd1;
    repeat (3) @(negedge clk);
    start = 1'b0; DA = 32'hDEAD_BEEF; DB = 32'h0BAD_F00D;
    issue(13, 1'b0, 32'd1000, 32'd7);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      issue($urandom_range(0, 15), 1'($urandom_range(0, 1)), pick(), pick());
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
